// File: rtl/ocr_pkg.sv
// Shared constants, FSM state encoding and the pixel abs-diff helper for
// the OCR template matcher.
package ocr_pkg;

  // Glyph store geometry
  localparam int NUM_TEMPLATES = 10;   // reference glyphs, indices 0..9
  localparam int PIXELS        = 256;  // 16x16 bytes per glyph
  localparam int DATA_W        = 8;    // pixel width
  localparam int SCORE_W       = 16;   // SAD width, holds 256*255 = 65280

  // Index/counter widths used on the memory interface
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  // Derived compare constants, pre-sized so comparisons stay width-clean
  localparam logic [IDX_W-1:0]   NUM_TMPL_IDX = IDX_W'(NUM_TEMPLATES);
  localparam logic [IDX_W-1:0]   LAST_TMPL    = IDX_W'(NUM_TEMPLATES - 1);
  localparam logic [CNT_W-1:0]   LAST_PIXEL   = CNT_W'(PIXELS - 1);

  // Starting value of the best-score tracker; any real SAD is below it
  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;

  // Sequencer states: IDLE -> SCAN -> DRAIN -> CMP -> (SCAN | DONE) -> IDLE
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CMP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Unsigned absolute difference of two pixels
  function automatic logic [DATA_W-1:0] abs_diff(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage : ocr_pkg

// File: rtl/ocr_sad_accum.sv
// One-stage pixel pipe followed by an absolute-difference accumulator.
// load captures a new pixel pair; the pair captured on the previous cycle
// is added into acc. clear empties both the pipe and the accumulator.
module ocr_sad_accum
  import ocr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  output logic [SCORE_W-1:0] acc
);

  logic [DATA_W-1:0]  pipe_a;
  logic [DATA_W-1:0]  pipe_b;
  logic               pipe_valid;
  logic [DATA_W-1:0]  diff;
  logic [SCORE_W-1:0] diff_ext;

  // Difference of the pair sitting in the pipe, zero-extended to score width
  assign diff     = abs_diff(pipe_a, pipe_b);
  assign diff_ext = {{(SCORE_W - DATA_W){1'b0}}, diff};

  // Pipe register and running sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_a     <= '0;
      pipe_b     <= '0;
      pipe_valid <= 1'b0;
      acc        <= '0;
    end else if (clear) begin
      pipe_valid <= 1'b0;
      acc        <= '0;
    end else begin
      // NOTE: non-blocking assignments let acc see the pipe contents from
      // before this edge, which is exactly the one-cycle pipeline offset.
      if (pipe_valid) begin
        acc <= acc + diff_ext;
      end
      pipe_valid <= load;
      if (load) begin
        pipe_a <= a;
        pipe_b <= b;
      end
    end
  end

endmodule : ocr_sad_accum

// File: rtl/ocr_match_sequencer.sv
// Walks every reference template in the glyph memory, accumulates the SAD
// against the selected test glyph and reports the lowest-SAD template.
// Each template costs PIXELS scan cycles plus one drain and one compare.
module ocr_match_sequencer
  import ocr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         test_sel,
  output logic               busy,
  output logic               done,
  output logic               start_err,
  output logic [3:0]         result_idx,
  output logic [SCORE_W-1:0] result_score,
  output logic [3:0]         mem_tmpl,
  output logic [3:0]         mem_test,
  output logic [7:0]         mem_count,
  input  logic [DATA_W-1:0]  mem_opA,
  input  logic [DATA_W-1:0]  mem_opT
);

  state_t             state;
  state_t             next_state;

  logic [IDX_W-1:0]   tmpl;
  logic [IDX_W-1:0]   test_q;
  logic [CNT_W-1:0]   count;
  logic [SCORE_W-1:0] best;
  logic [IDX_W-1:0]   best_idx;
  logic [SCORE_W-1:0] acc;

  logic               start_ok;
  logic               start_bad;
  logic               acc_clear;
  logic               pipe_load;

  // SAD datapath: pixel pipe plus accumulator
  ocr_sad_accum u_sad (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (acc_clear),
    .load  (pipe_load),
    .a     (mem_opA),
    .b     (mem_opT),
    .acc   (acc)
  );

  // Busy follows the state directly so an async reset drops it at once;
  // the memory address lines are forced to zero whenever we are idle.
  assign busy      = (state != ST_IDLE);
  assign mem_tmpl  = busy ? tmpl   : '0;
  assign mem_test  = busy ? test_q : '0;
  assign mem_count = busy ? count  : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-state datapath controls
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    next_state = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    acc_clear  = 1'b0;
    pipe_load  = 1'b0;

    case (state)
      ST_IDLE: begin
        acc_clear = 1'b1;
        if (start) begin
          if (test_sel < NUM_TMPL_IDX) begin
            start_ok   = 1'b1;
            next_state = ST_SCAN;
          end else begin
            start_bad  = 1'b1;
          end
        end
      end

      ST_SCAN: begin
        pipe_load = 1'b1;
        if (count == LAST_PIXEL) begin
          next_state = ST_DRAIN;
        end
      end

      // Pipe is not reloaded, so the last captured pixel is summed here
      ST_DRAIN: begin
        next_state = ST_CMP;
      end

      ST_CMP: begin
        acc_clear  = 1'b1;
        next_state = (tmpl == LAST_TMPL) ? ST_DONE : ST_SCAN;
      end

      ST_DONE: begin
        next_state = ST_IDLE;
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Counters, best-match tracking and result/pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmpl         <= '0;
      test_q       <= '0;
      count        <= '0;
      best         <= SCORE_MAX;
      best_idx     <= '0;
      result_idx   <= '0;
      result_score <= '0;
      done         <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      // done rises on the same edge that returns the FSM to IDLE
      done      <= (state == ST_DONE);
      start_err <= start_bad;

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            test_q   <= test_sel;
            tmpl     <= '0;
            count    <= '0;
            best     <= SCORE_MAX;
            best_idx <= '0;
          end
        end

        // count wraps from PIXELS-1 back to 0 on its own
        ST_SCAN: begin
          count <= count + 1'b1;
        end

        // Strict compare: an equal score keeps the earlier (lower) index
        ST_CMP: begin
          if (acc < best) begin
            best     <= acc;
            best_idx <= tmpl;
          end
          if (tmpl != LAST_TMPL) begin
            tmpl <= tmpl + 1'b1;
          end
        end

        ST_DONE: begin
          result_idx   <= best_idx;
          result_score <= best;
        end

        default: ;
      endcase
    end
  end

endmodule : ocr_match_sequencer

// File: tb/tb_ocr_match_sequencer.sv
// Self-checking bench for ocr_match_sequencer. Holds a behavioural glyph
// store (template bank on port A, test bank on port T, combinational read)
// and a reference SAD/argmin model computed directly from the glyph data.
module tb_ocr_match_sequencer;

  localparam int RUN_CYCLES = 2581;
  localparam int BUDGET     = 4000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  test_sel;
  logic        busy;
  logic        done;
  logic        start_err;
  logic [3:0]  result_idx;
  logic [15:0] result_score;
  logic [3:0]  mem_tmpl;
  logic [3:0]  mem_test;
  logic [7:0]  mem_count;
  logic [7:0]  mem_opA;
  logic [7:0]  mem_opT;

  logic [7:0]  tmpl_mem [16][256];
  logic [7:0]  test_mem [16][256];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  ocr_match_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .test_sel     (test_sel),
    .busy         (busy),
    .done         (done),
    .start_err    (start_err),
    .result_idx   (result_idx),
    .result_score (result_score),
    .mem_tmpl     (mem_tmpl),
    .mem_test     (mem_test),
    .mem_count    (mem_count),
    .mem_opA      (mem_opA),
    .mem_opT      (mem_opT)
  );

  assign mem_opA = tmpl_mem[mem_tmpl][mem_count];
  assign mem_opT = test_mem[mem_test][mem_count];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: SAD of every template against the test glyph, first minimum
  function automatic void model(input int sel, output int idx, output int score);
    int sad;
    int a;
    int b;
    idx   = -1;
    score = 0;
    for (int t = 0; t < 10; t++) begin
      sad = 0;
      for (int p = 0; p < 256; p++) begin
        a = int'(tmpl_mem[t][p]);
        b = int'(test_mem[sel][p]);
        sad += (a > b) ? a - b : b - a;
      end
      if (idx < 0 || sad < score) begin
        idx   = t;
        score = sad;
      end
    end
  endfunction

  task automatic fill_tmpl(input int t, input int v);
    for (int p = 0; p < 256; p++) tmpl_mem[t][p] = 8'(v);
  endtask

  task automatic fill_test(input int s, input int v);
    for (int p = 0; p < 256; p++) test_mem[s][p] = 8'(v);
  endtask

  task automatic rand_all();
    for (int t = 0; t < 16; t++)
      for (int p = 0; p < 256; p++) begin
        tmpl_mem[t][p] = 8'($urandom_range(0, 255));
        test_mem[t][p] = 8'($urandom_range(0, 255));
      end
  endtask

  // Start a run and wait for done; optionally pulse a second start mid-run.
  task automatic do_run(input string tag, input logic [3:0] sel, input int dup_at,
                        output int cycles, output bit seen);
    int busy_drop;
    bit busy_at_done;
    busy_drop    = 0;
    busy_at_done = 1'b1;
    cycles       = 0;
    seen         = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    test_sel = sel;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_mem_test"}, 32'(mem_test), 32'(sel));
    while (!seen && cycles < BUDGET) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == dup_at) begin
        start    = 1'b1;
        test_sel = sel ^ 4'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen         = 1'b1;
        busy_at_done = busy;
      end else if (!busy) begin
        busy_drop++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(RUN_CYCLES));
    check({tag, "_busy_held"}, 32'(busy_drop), 32'd0);
    check({tag, "_busy_low_at_done"}, 32'(busy_at_done), 32'd0);
  endtask

  // Compare the result registers, then confirm done is a single pulse,
  // results hold and the memory address lines idle at zero.
  task automatic check_result(input string tag, input int exp_idx, input int exp_score);
    check({tag, "_idx"}, 32'(result_idx), 32'(exp_idx));
    check({tag, "_score"}, 32'(result_score), 32'(exp_score));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idx_hold"}, 32'(result_idx), 32'(exp_idx));
    check({tag, "_idle_addr"}, {20'd0, mem_tmpl, mem_test, mem_count}, 32'd0);
  endtask

  task automatic model_run(input string tag, input logic [3:0] sel);
    int m_idx;
    int m_score;
    int cyc;
    bit seen;
    model(int'(sel), m_idx, m_score);
    do_run(tag, sel, -1, cyc, seen);
    check_result(tag, m_idx, m_score);
  endtask

  initial begin
    int cyc;
    int m_idx;
    int m_score;
    int done_cnt;
    bit seen;

    start    = 1'b0;
    test_sel = 4'd0;
    rst_n    = 1'b1;
    #3 rst_n = 1'b0;
    #10;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_start_err", 32'(start_err), 32'd0);
    check("rst_result_idx", 32'(result_idx), 32'd0);
    check("rst_result_score", 32'(result_score), 32'd0);
    check("rst_mem", {20'd0, mem_tmpl, mem_test, mem_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Template k = k*10, test slot 3 holds the same pattern as template 3
    for (int t = 0; t < 16; t++) begin
      fill_tmpl(t, t * 10);
      fill_test(t, t * 10);
    end
    do_run("t1", 4'd3, -1, cyc, seen);
    check_result("t1", 3, 0);

    // 2. Templates 2 and 5 equal the test glyph; every other one differs
    rand_all();
    for (int p = 0; p < 256; p++) begin
      tmpl_mem[2][p] = test_mem[5][p];
      tmpl_mem[5][p] = test_mem[5][p];
    end
    for (int t = 0; t < 10; t++)
      if (t != 2 && t != 5) tmpl_mem[t][0] = test_mem[5][0] ^ 8'h80;
    do_run("t2", 4'd5, -1, cyc, seen);
    check_result("t2", 2, 0);

    // 3. Worst-case score: templates all 0x00, test all 0xFF
    for (int t = 0; t < 16; t++) fill_tmpl(t, 0);
    fill_test(9, 255);
    do_run("t3", 4'd9, -1, cyc, seen);
    check_result("t3", 0, 65280);

    // 4. Single differing pixel, both orderings of the two values
    rand_all();
    for (int p = 0; p < 256; p++) begin
      tmpl_mem[0][p] = test_mem[4][p];
      for (int t = 1; t < 10; t++) tmpl_mem[t][p] = test_mem[4][p] ^ 8'hFF;
    end
    tmpl_mem[0][77] = 8'h10;
    test_mem[4][77] = 8'h05;
    do_run("t4a", 4'd4, -1, cyc, seen);
    check_result("t4a", 0, 11);
    tmpl_mem[0][77] = 8'h05;
    test_mem[4][77] = 8'h10;
    do_run("t4b", 4'd4, -1, cyc, seen);
    check_result("t4b", 0, 11);

    // 5. Async reset mid-scan: abandon the run, no done, clean rerun
    rand_all();
    @(negedge clk);
    start    = 1'b1;
    test_sel = 4'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (499) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy_now", 32'(busy), 32'd0);
    check("t5_mem_now", {20'd0, mem_tmpl, mem_test, mem_count}, 32'd0);
    check("t5_done_now", 32'(done), 32'd0);
    check("t5_score_cleared", 32'(result_score), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("t5_no_done", 32'(done_cnt), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    model_run("t5_rerun", 4'd6);

    // 6. Second start while busy is ignored; then an out-of-range start
    rand_all();
    model(7, m_idx, m_score);
    do_run("t6", 4'd7, 100, cyc, seen);
    check_result("t6", m_idx, m_score);
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("t6_single_done", 32'(done_cnt), 32'd0);

    @(negedge clk);
    start    = 1'b1;
    test_sel = 4'd12;
    @(posedge clk);
    #1;
    check("t6_err12_pulse", 32'(start_err), 32'd1);
    check("t6_err12_busy", 32'(busy), 32'd0);
    @(negedge clk);
    test_sel = 4'd10;
    @(posedge clk);
    #1;
    check("t6_err10_pulse", 32'(start_err), 32'd1);
    check("t6_err10_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("t6_err_clear", 32'(start_err), 32'd0);
    check("t6_err_idle", 32'(busy), 32'd0);

    // Random glyphs, highest valid slot and one random slot
    rand_all();
    model_run("rnd_sel9", 4'd9);
    rand_all();
    model_run("rnd_any", 4'($urandom_range(0, 9)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ocr_match_sequencer
